// File: rtl/resultbuf_reader.sv
// Result buffer with a per-entry valid bitmap. A rising edge on ARMINT walks every
// address in ascending order and streams each valid entry out once, then pulses DONE.
module resultbuf_reader #(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic          i_CLK,
  input  logic          i_RST_n,
  input  logic          i_RESULTBUF_EN,
  input  logic          i_RESULTBUF_WE,
  input  logic [DW-1:0] i_RESULTBUF_DATA,
  input  logic [AW-1:0] i_RESULTBUF_ADDR,
  input  logic          i_ARMINT,
  output logic          o_RD_VALID,
  input  logic          i_RD_READY,
  output logic [DW-1:0] o_RD_DATA,
  output logic [AW-1:0] o_RD_ADDR,
  output logic          o_BUSY,
  output logic          o_DONE,
  output logic          o_OVERRUN,
  output logic [1:0]    o_STATE
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, FETCH, PRESENT, DONE} state_t;

  // Read port: a word transfers on a rising edge where o_RD_VALID and i_RD_READY
  // are both 1; once raised, VALID, DATA and ADDR stay stable until that edge.

  state_t          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic            armint_q;
  logic [DEPTH-1:0] valid_q;
  logic [DW-1:0]   mem [DEPTH];
  logic            rd_valid_q, rd_valid_d;
  logic [DW-1:0]   rd_data_q, rd_data_d;
  logic [AW-1:0]   rd_addr_q, rd_addr_d;
  logic            overrun_q, overrun_d;
  logic            clr_valid;
  logic            wr_req, wr_accept, wr_drop, rise;

  assign wr_req    = i_RESULTBUF_EN & i_RESULTBUF_WE;
  assign wr_accept = wr_req & (state_q == IDLE);
  assign wr_drop   = wr_req & (state_q != IDLE);
  assign rise      = i_ARMINT & ~armint_q;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    rd_addr_d  = rd_addr_q;
    overrun_d  = overrun_q | wr_drop;
    clr_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d   = FETCH;
          ptr_d     = '0;
          overrun_d = 1'b0;
        end
      end
      FETCH: begin
        if (valid_q[ptr_q]) begin
          rd_data_d  = mem[ptr_q];
          rd_addr_d  = ptr_q;
          rd_valid_d = 1'b1;
          state_d    = PRESENT;
        end else if (ptr_q == LAST) begin
          state_d = DONE;
        end else begin
          ptr_d = ptr_q + AW'(1);
        end
      end
      PRESENT: begin
        if (i_RD_READY) begin
          rd_valid_d = 1'b0;
          clr_valid  = 1'b1;
          if (ptr_q == LAST) begin
            state_d = DONE;
          end else begin
            ptr_d   = ptr_q + AW'(1);
            state_d = FETCH;
          end
        end
      end
      DONE: begin
        ptr_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      armint_q   <= 1'b0;
      valid_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_addr_q  <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      armint_q   <= i_ARMINT;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_addr_q  <= rd_addr_d;
      overrun_q  <= overrun_d;
      if (wr_accept) valid_q[i_RESULTBUF_ADDR] <= 1'b1;
      if (clr_valid) valid_q[ptr_q] <= 1'b0;
    end
  end

  // Storage is not reset; stale words are hidden by the cleared bitmap.
  always_ff @(posedge i_CLK) begin
    if (wr_accept) mem[i_RESULTBUF_ADDR] <= i_RESULTBUF_DATA;
  end

  assign o_RD_VALID = rd_valid_q;
  assign o_RD_DATA  = rd_data_q;
  assign o_RD_ADDR  = rd_addr_q;
  assign o_BUSY     = (state_q != IDLE);
  assign o_DONE     = (state_q == DONE);
  assign o_OVERRUN  = overrun_q;
  assign o_STATE    = state_q;

endmodule

// File: tb/tb_resultbuf_reader.sv
// Bench for resultbuf_reader: a directed vector table, hand-built corner sequences,
// and randomized readouts scored against an array-based model of the buffer.
module tb_resultbuf_reader;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en, we, armint, ready;
  logic [DW-1:0] data;
  logic [AW-1:0] addr;
  logic          o_rd_valid, o_busy, o_done, o_overrun;
  logic [DW-1:0] o_rd_data;
  logic [AW-1:0] o_rd_addr;
  logic [1:0]    o_state;

  always #5 clk = ~clk;

  resultbuf_reader #(.DW(DW), .AW(AW)) dut (
    .i_CLK(clk), .i_RST_n(rst_n),
    .i_RESULTBUF_EN(en), .i_RESULTBUF_WE(we),
    .i_RESULTBUF_DATA(data), .i_RESULTBUF_ADDR(addr),
    .i_ARMINT(armint), .o_RD_VALID(o_rd_valid), .i_RD_READY(ready),
    .o_RD_DATA(o_rd_data), .o_RD_ADDR(o_rd_addr),
    .o_BUSY(o_busy), .o_DONE(o_done), .o_OVERRUN(o_overrun), .o_STATE(o_state)
  );

  int n_vec = 0;
  int n_mis = 0;

  // Reference model: buffer contents, which entries are pending, sticky overrun.
  logic [DW-1:0]    model_mem [DEPTH];
  bit               model_valid [DEPTH];
  bit               model_ovr;
  logic [AW+DW-1:0] exp_q[$];

  typedef struct {
    logic en, we; logic [AW-1:0] addr; logic [DW-1:0] data; logic arm, ready;
    logic e_valid; logic [AW-1:0] e_addr; logic [DW-1:0] e_data; logic e_busy, e_done;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void add_vec(int e, int w, int a, int d, int arm, int rdy,
                                  int ev, int ea, int ed, int eb, int edn);
    vec_t v;
    v.en = 1'(e); v.we = 1'(w); v.addr = AW'(a); v.data = DW'(d);
    v.arm = 1'(arm); v.ready = 1'(rdy);
    v.e_valid = 1'(ev); v.e_addr = AW'(ea); v.e_data = DW'(ed);
    v.e_busy = 1'(eb); v.e_done = 1'(edn);
    vecs.push_back(v);
  endfunction

  task automatic idle_write(input logic e, input logic w, input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
    en = e; we = w; addr = a; data = d;
    tick();
    en = 1'b0; we = 1'b0;
    if (e && w) begin
      model_mem[a] = d;
      model_valid[a] = 1'b1;
    end
  endtask

  task automatic clear_model();
    for (int a = 0; a < DEPTH; a++) model_valid[a] = 1'b0;
  endtask

  // One full readout from IDLE: every pending entry must appear once, ascending,
  // and DONE must land after one cycle per address plus one per PRESENT cycle.
  task automatic readout(input int ready_pct, input bit allow_drop, input bit arm_write,
                         input logic [AW-1:0] aw_addr, input logic [DW-1:0] aw_data);
    int cycles, presents, dones;
    bit hold_pending;
    logic [AW+DW-1:0] got, held;
    if (arm_write) begin
      model_mem[aw_addr] = aw_data;
      model_valid[aw_addr] = 1'b1;
    end
    exp_q.delete();
    for (int a = 0; a < DEPTH; a++)
      if (model_valid[a]) exp_q.push_back({AW'(a), model_mem[a]});
    en = arm_write; we = arm_write; addr = aw_addr; data = aw_data;
    armint = 1'b1; ready = 1'b0;
    tick();
    en = 1'b0; we = 1'b0; armint = 1'b0;
    model_ovr = 1'b0;
    check("ovr_clear_on_rise", 64'(o_overrun), 64'(model_ovr));
    cycles = 0; presents = 0; dones = 0; hold_pending = 1'b0; held = '0;
    while (dones == 0 && cycles < 8 * DEPTH) begin
      ready = ($urandom_range(99) < ready_pct);
      if (allow_drop && (cycles == 0 || $urandom_range(7) == 0)) begin
        en = 1'b1; we = 1'b1;
        addr = AW'($urandom_range(DEPTH - 1)); data = $urandom;
        model_ovr = 1'b1;
      end else begin
        en = 1'b0; we = 1'b0;
      end
      got = {o_rd_addr, o_rd_data};
      if (hold_pending) check("hold_stable", 64'({o_rd_valid, got}), 64'({1'b1, held}));
      hold_pending = 1'b0;
      if (o_rd_valid) begin
        presents++;
        if (ready) begin
          if (exp_q.size() > 0) check("word", 64'(got), 64'(exp_q.pop_front()));
          else check("extra_word", 64'(got), 64'(0) - 64'(1));
        end else begin
          hold_pending = 1'b1;
          held = got;
        end
      end
      tick();
      cycles++;
      if (o_done) dones++;
    end
    en = 1'b0; we = 1'b0; ready = 1'b0;
    check("done_seen", 64'(dones), 64'(1));
    check("done_latency", 64'(cycles), 64'(DEPTH + presents));
    check("words_left", 64'(exp_q.size()), 64'(0));
    check("overrun", 64'(o_overrun), 64'(model_ovr));
    clear_model();
    tick();
    check("done_one_cycle", 64'({o_done, o_busy, o_rd_valid}), 64'(0));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [AW-1:0] a0;
    rst_n = 1'b0; en = 1'b0; we = 1'b0; armint = 1'b0; ready = 1'b0;
    data = '0; addr = '0; model_ovr = 1'b0;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 64'({o_rd_valid, o_rd_addr, o_rd_data, o_busy, o_done, o_overrun}), 64'(0));
    rst_n = 1'b1;
    tick();
    check("post_reset_idle", 64'({o_rd_valid, o_rd_addr, o_rd_data, o_busy, o_done, o_overrun}), 64'(0));

    // Two entries read back with READY held high, then an empty second readout.
    add_vec(1, 1, 2, 'h11, 0, 0,  0, 0, 0, 0, 0);
    add_vec(1, 1, 5, 'h22, 0, 0,  0, 0, 0, 0, 0);
    add_vec(0, 0, 0, 0,    1, 0,  0, 0, 0, 1, 0);
    add_vec(0, 0, 0, 0,    0, 1,  0, 0, 0, 1, 0);
    add_vec(0, 0, 0, 0,    0, 1,  0, 0, 0, 1, 0);
    add_vec(0, 0, 0, 0,    0, 1,  1, 2, 'h11, 1, 0);
    add_vec(0, 0, 0, 0,    0, 1,  0, 2, 'h11, 1, 0);
    add_vec(0, 0, 0, 0,    0, 1,  0, 2, 'h11, 1, 0);
    add_vec(0, 0, 0, 0,    0, 1,  0, 2, 'h11, 1, 0);
    add_vec(0, 0, 0, 0,    0, 1,  1, 5, 'h22, 1, 0);
    add_vec(0, 0, 0, 0,    0, 1,  0, 5, 'h22, 1, 0);
    for (int i = 0; i < DEPTH - 7; i++) add_vec(0, 0, 0, 0, 0, 1, 0, 5, 'h22, 1, 0);
    add_vec(0, 0, 0, 0,    0, 1,  0, 5, 'h22, 1, 1);
    add_vec(0, 0, 0, 0,    0, 1,  0, 5, 'h22, 0, 0);
    add_vec(0, 0, 0, 0,    1, 1,  0, 5, 'h22, 1, 0);
    for (int i = 0; i < DEPTH - 1; i++) add_vec(0, 0, 0, 0, 0, 1, 0, 5, 'h22, 1, 0);
    add_vec(0, 0, 0, 0,    0, 1,  0, 5, 'h22, 1, 1);
    add_vec(0, 0, 0, 0,    0, 1,  0, 5, 'h22, 0, 0);
    foreach (vecs[i]) begin
      en = vecs[i].en; we = vecs[i].we; addr = vecs[i].addr; data = vecs[i].data;
      armint = vecs[i].arm; ready = vecs[i].ready;
      tick();
      check($sformatf("vec%0d", i),
            64'({o_rd_valid, o_rd_addr, o_rd_data, o_busy, o_done, o_overrun}),
            64'({vecs[i].e_valid, vecs[i].e_addr, vecs[i].e_data, vecs[i].e_busy, vecs[i].e_done, 1'b0}));
    end
    en = 1'b0; we = 1'b0; armint = 1'b0; ready = 1'b0;

    // READY held low: the presented word must not move for five cycles.
    a0 = '0;
    idle_write(1'b1, 1'b1, a0, 32'hA5A5_0001);
    armint = 1'b1; tick(); armint = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("hold5", 64'({o_rd_valid, o_rd_addr, o_rd_data}), 64'({1'b1, a0, 32'hA5A5_0001}));
      tick();
    end
    ready = 1'b1; tick();
    check("hold5_release", 64'(o_rd_valid), 64'(0));
    n = 0;
    while (!o_done && n < 2 * DEPTH) begin
      check("hold5_no_more", 64'(o_rd_valid), 64'(0));
      tick(); n++;
    end
    check("hold5_done", 64'(o_done), 64'(1));
    ready = 1'b0; clear_model(); tick();

    // Write on the same edge as the rise is included and emitted first.
    idle_write(1'b1, 1'b1, AW'(7), 32'h0000_0077);
    readout(100, 1'b0, 1'b1, a0, 32'h0000_0033);

    // Dropped writes set a sticky overrun that survives until the next rise.
    idle_write(1'b1, 1'b1, AW'(0), 32'h10);
    idle_write(1'b1, 1'b1, AW'(3), 32'h30);
    readout(50, 1'b1, 1'b0, a0, '0);
    repeat (3) begin
      tick();
      check("ovr_sticky", 64'(o_overrun), 64'(1));
    end
    readout(100, 1'b0, 1'b0, a0, '0);

    // Reset in the middle of PRESENT aborts the readout and empties the bitmap.
    idle_write(1'b1, 1'b1, AW'(4), 32'hCAFE_0004);
    armint = 1'b1; ready = 1'b0; tick(); armint = 1'b0;
    en = 1'b1; we = 1'b1; addr = AW'(1); data = 32'h1;
    n = 0;
    while (!o_rd_valid && n < 2 * DEPTH) begin
      tick(); en = 1'b0; we = 1'b0; n++;
    end
    en = 1'b0; we = 1'b0;
    check("reach_present", 64'({o_rd_valid, o_overrun}), 64'(3));
    #3 rst_n = 1'b0;
    #1;
    check("async_reset", 64'({o_rd_valid, o_rd_addr, o_rd_data, o_busy, o_done, o_overrun}), 64'(0));
    repeat (2) begin
      tick();
      check("reset_no_done", 64'({o_done, o_busy}), 64'(0));
    end
    rst_n = 1'b1;
    clear_model(); model_ovr = 1'b0;
    tick();
    readout(100, 1'b0, 1'b0, a0, '0);

    // Randomized rounds against the model.
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(2 * DEPTH);
      for (int k = 0; k < n; k++)
        idle_write(1'($urandom_range(1)), 1'($urandom_range(1)),
                   AW'($urandom_range(DEPTH - 1)), $urandom);
      readout($urandom_range(100, 30), 1'($urandom_range(1)), 1'($urandom_range(1)),
              AW'($urandom_range(DEPTH - 1)), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
